// File: rtl/kb_pkg.sv
// kb_pkg: shared constants and types for the PS/2 set-2 keyboard event path.
// Event layout is {ext, brk, code}.
package kb_pkg;

  localparam int CODE_W = 8;
  localparam int EVT_W  = 10;
  localparam int SKIP_W = 3;

  localparam logic [7:0] BRK    = 8'hF0;
  localparam logic [7:0] EXT    = 8'hE0;
  localparam logic [7:0] PAUSE  = 8'hE1;
  localparam logic [7:0] BAT_OK = 8'hAA;
  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
  localparam logic [7:0] ECHO   = 8'hEE;
  localparam logic [7:0] ERR_LO = 8'h00;
  localparam logic [7:0] ERR_HI = 8'hFF;

  // Pause/Break sends E1 followed by seven more bytes.
  localparam logic [SKIP_W-1:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } dec_state_e;

  typedef struct packed {
    logic              ext;
    logic              brk;
    logic [CODE_W-1:0] code;
  } kb_evt_t;

  typedef struct packed {
    logic              ext;
    logic [CODE_W-1:0] code;
  } kb_key_t;

  // Controller status bytes that never form a key event on their own.
  function automatic logic is_noise(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      BAT_OK, ACK, RESEND, ECHO, ERR_LO, ERR_HI: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic kb_evt_t mk_evt(
    input logic       ext,
    input logic       brk,
    input logic [7:0] code
  );
    kb_evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// kb_fifo: first-word-fall-through queue with registered count.
// Head entry is always visible on dout; dout reads 0 when empty.
module kb_fifo
  import kb_pkg::*;
#(
  parameter int W_SIZE = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 2 ** W_SIZE;
  localparam logic [W_SIZE:0] FULL_CNT = {1'b1, {W_SIZE{1'b0}}};
  localparam logic [W_SIZE:0] CNT_ONE  = (W_SIZE + 1)'(1);
  localparam logic [W_SIZE-1:0] PTR_ONE = W_SIZE'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [W_SIZE-1:0] wptr_q, wptr_d;
  logic [W_SIZE-1:0] rptr_q, rptr_d;
  logic [W_SIZE:0]   cnt_q, cnt_d;
  logic              do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // A write at full is only taken when the head leaves this cycle.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  assign dout = empty ? '0 : mem_q[rptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr) wptr_d = wptr_q + PTR_ONE;
    if (do_rd) rptr_d = rptr_q + PTR_ONE;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= din;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: PS/2 set-2 byte stream to buffered key events.
// Decodes make/break/E0/Pause sequences, filters typematic repeats.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int W_SIZE           = 2,
  parameter bit MAKE_EN          = 1'b1,
  parameter bit BRK_EN           = 1'b1,
  parameter bit TYPEMATIC_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_data,
  input  logic       scan_done_tick,
  input  logic       rd_key_code,
  input  logic       clr_ovf,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       kb_buf_empty,
  output logic       kb_buf_full,
  output logic       overflow
);

  dec_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  kb_key_t           held_q, held_d;
  logic              held_vld_q, held_vld_d;
  logic              ovf_q, ovf_d;

  logic              evt_vld;
  kb_evt_t           evt;
  kb_key_t           evt_key;
  logic              held_match;
  logic              suppress;
  logic              push;
  logic              drop;
  logic [EVT_W-1:0]  head_raw;
  kb_evt_t           head;

  // Byte-level sequence decoder; emits at most one event per byte.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    evt_vld = 1'b0;
    evt     = '0;
    if (scan_done_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            (scan_data == EXT):   state_d = ST_EXT;
            (scan_data == BRK):   state_d = ST_BRK;
            (scan_data == PAUSE): begin
              state_d = ST_PAUSE;
              skip_d  = PAUSE_SKIP;
            end
            is_noise(scan_data): state_d = ST_IDLE;
            default: begin
              evt_vld = 1'b1;
              evt     = mk_evt(1'b0, 1'b0, scan_data);
            end
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            (scan_data == BRK): state_d = ST_EXTBRK;
            (scan_data == EXT): state_d = ST_EXT;
            default: begin
              evt_vld = 1'b1;
              evt     = mk_evt(1'b1, 1'b0, scan_data);
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          evt_vld = 1'b1;
          evt     = mk_evt(1'b0, 1'b1, scan_data);
          state_d = ST_IDLE;
        end
        ST_EXTBRK: begin
          evt_vld = 1'b1;
          evt     = mk_evt(1'b1, 1'b1, scan_data);
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            evt_vld = 1'b1;
            evt     = mk_evt(1'b0, 1'b0, PAUSE);
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign evt_key.ext  = evt.ext;
  assign evt_key.code = evt.code;
  assign held_match   = held_vld_q && (held_q == evt_key);

  // Repeat makes of the held key are swallowed when filtering.
  assign suppress = TYPEMATIC_FILTER && evt_vld
                 && !evt.brk && held_match;

  // Held-key tracking runs regardless of the push enables.
  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (evt_vld && !suppress) begin
      if (!evt.brk) begin
        held_d     = evt_key;
        held_vld_d = 1'b1;
      end else if (held_match) begin
        held_vld_d = 1'b0;
      end
    end
  end

  assign push = evt_vld && !suppress
             && (evt.brk ? BRK_EN : MAKE_EN);

  assign drop = push && kb_buf_full
             && !(rd_key_code && !kb_buf_empty);

  // A fresh drop wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Decoder, held-key and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  kb_fifo #(
    .W_SIZE (W_SIZE),
    .DATA_W (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .rd    (rd_key_code),
    .din   (evt),
    .dout  (head_raw),
    .empty (kb_buf_empty),
    .full  (kb_buf_full)
  );

  assign head     = head_raw;
  assign key_code = head.code;
  assign key_ext  = head.ext;
  assign key_brk  = head.brk;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_kb_event_fifo.sv
// tb_kb_event_fifo: checks kb_event_fifo with filter on and off.
// Table vectors, corner sequences and a random run against a queue model.
module tb_kb_event_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_data;
  logic       scan_done_tick;
  logic       rd_key_code;
  logic       clr_ovf;

  logic [7:0] kc  [2];
  logic       ke  [2];
  logic       kbk [2];
  logic       emp [2];
  logic       ful [2];
  logic       ovf [2];

  int n_tests = 0;
  int n_fail  = 0;

  kb_event_fifo #(
    .W_SIZE(2), .MAKE_EN(1'b1), .BRK_EN(1'b1),
    .TYPEMATIC_FILTER(1'b1)
  ) u_filt (
    .clk(clk), .reset(reset),
    .scan_data(scan_data), .scan_done_tick(scan_done_tick),
    .rd_key_code(rd_key_code), .clr_ovf(clr_ovf),
    .key_code(kc[0]), .key_ext(ke[0]), .key_brk(kbk[0]),
    .kb_buf_empty(emp[0]), .kb_buf_full(ful[0]),
    .overflow(ovf[0])
  );

  kb_event_fifo #(
    .W_SIZE(2), .MAKE_EN(1'b1), .BRK_EN(1'b1),
    .TYPEMATIC_FILTER(1'b0)
  ) u_raw (
    .clk(clk), .reset(reset),
    .scan_data(scan_data), .scan_done_tick(scan_done_tick),
    .rd_key_code(rd_key_code), .clr_ovf(clr_ovf),
    .key_code(kc[1]), .key_ext(ke[1]), .key_brk(kbk[1]),
    .kb_buf_empty(emp[1]), .kb_buf_full(ful[1]),
    .overflow(ovf[1])
  );

  always #5 clk = ~clk;

  // Reference model: prefix flags, per-DUT held key and event queue.
  bit         m_ext, m_brk;
  int         m_pause;
  logic [9:0] mq [2][$];
  bit         hv [2];
  logic [8:0] held [2];
  bit         movf [2];

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause = 0;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      hv[k] = 0; held[k] = '0; movf[k] = 0;
    end
  endtask

  task automatic model_parse(input logic [7:0] b,
                             output bit ev, output logic [9:0] e);
    ev = 0; e = '0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin ev = 1; e = {2'b00, 8'hE1}; end
    end else if (m_brk) begin
      ev = 1; e = {m_ext, 1'b1, b};
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (!m_ext && b == 8'hE1) begin
      m_pause = 7;
    end else if (!m_ext && (b == 8'hAA || b == 8'hFA ||
               b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF)) begin
      ev = 0;
    end else begin
      ev = 1; e = {m_ext, 1'b0, b};
      m_ext = 0;
    end
  endtask

  task automatic model_cycle(input logic [7:0] b, input bit tick,
                             input bit rd, input bit clr);
    bit ev, pop, push, drop;
    logic [9:0] e;
    logic [8:0] key;
    ev = 0; e = '0;
    if (tick) model_parse(b, ev, e);
    key = {e[9], e[7:0]};
    for (int k = 0; k < 2; k++) begin
      pop  = rd && (mq[k].size() > 0);
      push = 0;
      drop = 0;
      if (ev) begin
        if (!e[8]) begin
          if (!(k == 0 && hv[k] && held[k] == key)) begin
            held[k] = key; hv[k] = 1; push = 1;
          end
        end else begin
          if (hv[k] && held[k] == key) hv[k] = 0;
          push = 1;
        end
      end
      if (pop) void'(mq[k].pop_front());
      if (push) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(e);
        else drop = 1;
      end
      if (drop) movf[k] = 1;
      else if (clr) movf[k] = 0;
    end
  endtask

  task automatic chk(input string nm, input int k);
    logic [9:0]  h;
    logic [12:0] got, exp;
    h = (mq[k].size() > 0) ? mq[k][0] : 10'h0;
    exp = {h, mq[k].size() == 0, mq[k].size() == DEPTH, movf[k]};
    got = {ke[k], kbk[k], kc[k], emp[k], ful[k], ovf[k]};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got ext/brk/code/emp/full/ovf=%b expected %b",
               nm, k, got, exp);
    end
  endtask

  task automatic xchk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] b, input bit tick,
                      input bit rd, input bit clr);
    scan_data      = b;
    scan_done_tick = tick;
    rd_key_code    = rd;
    clr_ovf        = clr;
    @(posedge clk);
    model_cycle(b, tick, rd, clr);
    @(negedge clk);
    scan_done_tick = 0;
    rd_key_code    = 0;
    clr_ovf        = 0;
    chk("model", 0);
    chk("model", 1);
  endtask

  task automatic key(input logic [7:0] b);
    step(b, 1, 0, 0);
  endtask

  task automatic pop();
    step(8'h00, 0, 1, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    bit tick, rd, clr;
    logic [7:0] code;
    bit ext, brk, empty, full, ov;
  } vec_t;

  vec_t tv [$];

  task automatic add(input logic [7:0] b, input bit tick, input bit rd,
                     input logic [7:0] code, input bit ext, input bit brk,
                     input bit empty);
    vec_t v;
    v.b = b; v.tick = tick; v.rd = rd; v.clr = 0;
    v.code = code; v.ext = ext; v.brk = brk;
    v.empty = empty; v.full = 0; v.ov = 0;
    tv.push_back(v);
  endtask

  logic [7:0] pool [12] = '{8'h1C, 8'h75, 8'h14, 8'h1C, 8'hE0, 8'hF0,
                            8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'h29};

  initial begin
    reset = 1; scan_data = 0; scan_done_tick = 0;
    rd_key_code = 0; clr_ovf = 0;
    do_reset();
    chk("reset", 0);
    chk("reset", 1);
    xchk("reset_empty", {31'd0, emp[0]}, 32'd1);
    xchk("reset_code", {24'd0, kc[0]}, 32'd0);

    add(8'h1C, 1, 0, 8'h1C, 0, 0, 0);
    add(8'hF0, 1, 0, 8'h1C, 0, 0, 0);
    add(8'h1C, 1, 0, 8'h1C, 0, 0, 0);
    add(8'h00, 0, 1, 8'h1C, 0, 1, 0);
    add(8'h00, 0, 1, 8'h00, 0, 0, 1);
    add(8'hE0, 1, 0, 8'h00, 0, 0, 1);
    add(8'h75, 1, 0, 8'h75, 1, 0, 0);
    add(8'hE0, 1, 0, 8'h75, 1, 0, 0);
    add(8'hF0, 1, 0, 8'h75, 1, 0, 0);
    add(8'h75, 1, 0, 8'h75, 1, 0, 0);
    add(8'h00, 0, 1, 8'h75, 1, 1, 0);
    add(8'h00, 0, 1, 8'h00, 0, 0, 1);
    add(8'hAA, 1, 0, 8'h00, 0, 0, 1);
    add(8'hFA, 1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].b, tv[i].tick, tv[i].rd, tv[i].clr);
      n_tests++;
      if ({kc[0], ke[0], kbk[0], emp[0], ful[0], ovf[0]} !==
          {tv[i].code, tv[i].ext, tv[i].brk,
           tv[i].empty, tv[i].full, tv[i].ov}) begin
        n_fail++;
        $display("FAIL tv[%0d]: got %h/%b%b%b%b%b expected %h/%b%b%b%b%b",
                 i, kc[0], ke[0], kbk[0], emp[0], ful[0], ovf[0],
                 tv[i].code, tv[i].ext, tv[i].brk,
                 tv[i].empty, tv[i].full, tv[i].ov);
      end
    end

    key(8'h1C); key(8'h1C); key(8'h1C); key(8'hF0); key(8'h1C);
    xchk("typ_filt_full", {31'd0, ful[0]}, 32'd0);
    xchk("typ_raw_full", {31'd0, ful[1]}, 32'd1);
    pop(); pop();
    xchk("typ_filt_empty", {31'd0, emp[0]}, 32'd1);
    xchk("typ_raw_nonempty", {31'd0, emp[1]}, 32'd0);
    pop(); pop();
    xchk("typ_raw_empty", {31'd0, emp[1]}, 32'd1);

    key(8'h15); key(8'h1D); key(8'h24); key(8'h2D);
    xchk("ovf_full4", {31'd0, ful[0]}, 32'd1);
    xchk("ovf_none4", {31'd0, ovf[0]}, 32'd0);
    key(8'h2C);
    xchk("ovf_set5", {31'd0, ovf[0]}, 32'd1);
    step(8'h36, 1, 0, 1);
    xchk("ovf_clr_vs_drop", {31'd0, ovf[0]}, 32'd1);
    step(8'h00, 0, 0, 1);
    xchk("ovf_cleared", {31'd0, ovf[0]}, 32'd0);
    step(8'h35, 1, 1, 0);
    xchk("popush_full", {31'd0, ful[0]}, 32'd1);
    xchk("popush_head", {24'd0, kc[0]}, 32'h1D);
    xchk("popush_ovf", {31'd0, ovf[0]}, 32'd0);
    pop(); pop(); pop();
    xchk("popush_tail", {24'd0, kc[0]}, 32'h35);
    pop();
    xchk("drain_empty", {31'd0, emp[0]}, 32'd1);

    key(8'hE1); key(8'h14); key(8'h77); key(8'hE1);
    key(8'hF0); key(8'h14); key(8'hF0); key(8'h77);
    xchk("pause_code", {24'd0, kc[0]}, 32'hE1);
    key(8'h1C);
    pop();
    xchk("pause_single", {22'd0, ke[0], kbk[0], kc[0]}, 32'h01C);
    pop();
    xchk("pause_drain", {31'd0, emp[0]}, 32'd1);

    key(8'hE0); key(8'hF0);
    do_reset();
    key(8'h1C);
    xchk("rst_mid_evt", {22'd0, ke[0], kbk[0], kc[0]}, 32'h01C);
    pop();
    xchk("rst_mid_one", {31'd0, emp[0]}, 32'd1);

    for (int i = 0; i < 4000; i++) begin
      step(pool[$urandom_range(0, 11)],
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0);
      if (i == 2000) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
